// File: rtl/soc_system_sysid_pkg.sv
// Shared constants for the extended sysid slave: register map, CONTROL bits,
// CAPS layout, register-select type and the byte-lane merge helper.
package soc_system_sysid_pkg;

    localparam int ADDR_SYSID      = 0;
    localparam int ADDR_TIMESTAMP  = 1;
    localparam int ADDR_CAPS       = 2;
    localparam int ADDR_SCRATCH    = 3;
    localparam int ADDR_UPTIME_LO  = 4;
    localparam int ADDR_UPTIME_HI  = 5;
    localparam int ADDR_CONTROL    = 6;
    localparam int ADDR_RESERVED   = 7;
    localparam int ADDR_USER_BASE  = 8;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    localparam int CAPS_NUSER_LSB   = 0;
    localparam int CAPS_VERSION_LSB = 8;

    typedef enum logic [3:0] {
        REG_SYSID,
        REG_TIMESTAMP,
        REG_CAPS,
        REG_SCRATCH,
        REG_UPTIME_LO,
        REG_UPTIME_HI,
        REG_CONTROL,
        REG_USER,
        REG_NONE
    } reg_sel_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) result[8*b +: 8] = new_val[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/soc_system_sysid_uptime.sv
// 64-bit free-running uptime counter with clear and freeze; a read of the low
// word captures the high word into a shadow so a later HI read is coherent.
module soc_system_sysid_uptime
    import soc_system_sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        freeze,
    input  logic        clear,
    input  logic        lo_read,
    output logic [31:0] uptime_lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] count_q, count_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d     = count_q;
        hi_shadow_d = hi_shadow_q;
        if (clear) begin
            count_d = '0;
        end else if (!freeze) begin
            count_d = count_q + 64'd1;
        end
        // Snapshot uses the pre-edge count, i.e. the same sample the LO read returns.
        if (lo_read) begin
            hi_shadow_d = count_q[63:32];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample
    // their inputs from the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            hi_shadow_q <= '0;
        end else begin
            count_q     <= count_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end

    assign uptime_lo = count_q[31:0];
    assign hi_shadow = hi_shadow_q;

endmodule

// File: rtl/soc_system_sysid_ext.sv
// Avalon-MM system-identification slave: fixed ID words, capability word,
// scratch and control registers, uptime counter and N read-only user words.
module soc_system_sysid_ext
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter logic [7:0]  VERSION       = 8'd2,
    parameter int          N_USER        = 4,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int          ADDR_W        = 8
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [ADDR_W-1:0]                          address,
    input  logic                                       read,
    input  logic                                       write,
    input  logic [31:0]                                writedata,
    input  logic [3:0]                                 byteenable,
    output logic [31:0]                                readdata,
    output logic                                       readdatavalid,
    input  logic [(N_USER == 0 ? 1 : 32*N_USER)-1:0]   user_words
);

    reg_sel_e    sel;
    logic        user_hit;
    logic [31:0] user_rdata;
    logic        wr_en;
    logic        ctrl_wr;
    logic        clear_pulse;
    logic        lo_read;
    logic [31:0] uptime_lo;
    logic [31:0] hi_shadow;
    logic [31:0] caps_word;
    logic [31:0] ctrl_word;
    logic [31:0] rdata_mux;

    logic [31:0] scratch_q,  scratch_d;
    logic        freeze_q,   freeze_d;
    logic [31:0] readdata_q, readdata_d;
    logic        rvalid_q,   rvalid_d;

    if (N_USER > 0) begin : g_user
        always_comb begin
            user_hit   = 1'b0;
            user_rdata = '0;
            for (int k = 0; k < N_USER; k++) begin
                if (address == ADDR_W'(ADDR_USER_BASE + k)) begin
                    user_hit   = 1'b1;
                    user_rdata = user_words[32*k +: 32];
                end
            end
        end
    end else begin : g_no_user
        assign user_hit   = 1'b0;
        assign user_rdata = '0;
    end

    always_comb begin
        sel = REG_NONE;
        if      (address == ADDR_W'(ADDR_SYSID))     sel = REG_SYSID;
        else if (address == ADDR_W'(ADDR_TIMESTAMP)) sel = REG_TIMESTAMP;
        else if (address == ADDR_W'(ADDR_CAPS))      sel = REG_CAPS;
        else if (address == ADDR_W'(ADDR_SCRATCH))   sel = REG_SCRATCH;
        else if (address == ADDR_W'(ADDR_UPTIME_LO)) sel = REG_UPTIME_LO;
        else if (address == ADDR_W'(ADDR_UPTIME_HI)) sel = REG_UPTIME_HI;
        else if (address == ADDR_W'(ADDR_CONTROL))   sel = REG_CONTROL;
        else if (user_hit)                           sel = REG_USER;
    end

    // A write coinciding with a read is a protocol violation; the read wins.
    always_comb begin
        wr_en       = write && !read;
        ctrl_wr     = wr_en && (sel == REG_CONTROL) && byteenable[0];
        clear_pulse = ctrl_wr && writedata[CTRL_CLEAR_BIT];
        lo_read     = read && (sel == REG_UPTIME_LO);

        scratch_d = scratch_q;
        if (wr_en && (sel == REG_SCRATCH)) begin
            scratch_d = merge_bytes(scratch_q, writedata, byteenable);
        end

        freeze_d = freeze_q;
        if (ctrl_wr) begin
            freeze_d = writedata[CTRL_FREEZE_BIT];
        end
    end

    soc_system_sysid_uptime u_uptime (
        .clock     (clock),
        .reset     (reset),
        .freeze    (freeze_q),
        .clear     (clear_pulse),
        .lo_read   (lo_read),
        .uptime_lo (uptime_lo),
        .hi_shadow (hi_shadow)
    );

    always_comb begin
        caps_word                              = '0;
        caps_word[CAPS_VERSION_LSB +: 8]       = VERSION;
        caps_word[CAPS_NUSER_LSB +: 8]         = 8'(N_USER);
        ctrl_word                              = '0;
        ctrl_word[CTRL_FREEZE_BIT]             = freeze_q;

        unique case (sel)
            REG_SYSID:     rdata_mux = SYSTEM_ID;
            REG_TIMESTAMP: rdata_mux = TIMESTAMP;
            REG_CAPS:      rdata_mux = caps_word;
            REG_SCRATCH:   rdata_mux = scratch_q;
            REG_UPTIME_LO: rdata_mux = uptime_lo;
            REG_UPTIME_HI: rdata_mux = hi_shadow;
            REG_CONTROL:   rdata_mux = ctrl_word;
            REG_USER:      rdata_mux = user_rdata;
            default:       rdata_mux = '0;
        endcase

        readdata_d = read ? rdata_mux : readdata_q;
        rvalid_d   = read;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch_q  <= SCRATCH_RESET;
            freeze_q   <= 1'b0;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            scratch_q  <= scratch_d;
            freeze_q   <= freeze_d;
            readdata_q <= readdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Self-checking bench for soc_system_sysid_ext: directed steps plus a random
// phase, checked against a behavioural model of the register map and uptime.
module tb_soc_system_sysid_ext;

    localparam logic [31:0] SYSTEM_ID_P     = 32'hA2D4_5002;
    localparam logic [31:0] TIMESTAMP_P     = 32'h5912_8FF8;
    localparam logic [7:0]  VERSION_P       = 8'd2;
    localparam int          N_USER_P        = 4;
    localparam logic [31:0] SCRATCH_RESET_P = 32'h1234_5678;
    localparam int          ADDR_W_P        = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [127:0] user_words;

    always #5 clock = ~clock;

    soc_system_sysid_ext #(
        .SYSTEM_ID     (SYSTEM_ID_P),
        .TIMESTAMP     (TIMESTAMP_P),
        .VERSION       (VERSION_P),
        .N_USER        (N_USER_P),
        .SCRATCH_RESET (SCRATCH_RESET_P),
        .ADDR_W        (ADDR_W_P)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .user_words    (user_words)
    );

    int checks = 0;
    int errors = 0;

    // Model: uptime = base + edges elapsed since 'up_edge', or base while frozen.
    longint unsigned cyc = 0;
    longint unsigned up_edge;
    logic [63:0]     up_base;
    bit              frz_m;
    logic [31:0]     hi_m;
    logic [31:0]     scr_m;
    logic [31:0]     uw [4];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] up_now();
        return frz_m ? up_base : up_base + 64'(cyc - up_edge);
    endfunction

    task automatic model_reset();
        scr_m   = SCRATCH_RESET_P;
        hi_m    = '0;
        up_base = '0;
        up_edge = cyc;
        frz_m   = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        logic [63:0] u;
        u = up_now();
        if (a >= 8'd8 && a < 8'd12) return uw[int'(a) - 8];
        case (a)
            8'd0:    return SYSTEM_ID_P;
            8'd1:    return TIMESTAMP_P;
            8'd2:    return {16'h0000, VERSION_P, 8'(N_USER_P)};
            8'd3:    return scr_m;
            8'd4:    return u[31:0];
            8'd5:    return hi_m;
            8'd6:    return {30'd0, frz_m, 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_user();
        user_words = {uw[3], uw[2], uw[1], uw[0]};
    endtask

    // Issued at a falling edge; the write lands on the following rising edge.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(negedge clock);
        write      = 1'b0;
        byteenable = 4'h0;
        if (a == 8'd3) begin
            for (int b = 0; b < 4; b++) if (be[b]) scr_m[8*b +: 8] = d[8*b +: 8];
        end
        if (a == 8'd6 && be[0]) begin
            up_base = d[0] ? 64'd0 : up_now();
            up_edge = cyc;
            frz_m   = d[1];
        end
    endtask

    task automatic chk_read(input logic [7:0] a, input string tag);
        logic [31:0] e;
        logic [63:0] u;
        u       = up_now();
        e       = exp_read(a);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        check({tag, ".valid"}, 64'(readdatavalid), 64'd1);
        check({tag, ".data"}, 64'(readdata), 64'(e));
        if (a == 8'd4) hi_m = u[63:32];
    endtask

    initial begin
        logic [31:0] held;
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
        for (int k = 0; k < 4; k++) uw[k] = 32'h1000_0000 + 32'(k);
        push_user();
        model_reset();

        repeat (3) @(negedge clock);
        check("rst.readdata", 64'(readdata), 64'd0);
        check("rst.valid", 64'(readdatavalid), 64'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("idle.valid", 64'(readdatavalid), 64'd0);

        chk_read(8'd0, "sysid");
        chk_read(8'd1, "timestamp");
        chk_read(8'd2, "caps");
        @(negedge clock);
        check("hold.valid", 64'(readdatavalid), 64'd0);
        check("hold.data", 64'(readdata), 64'h0000_0204);

        do_write(8'd3, 32'hDEAD_BEEF, 4'b1111);
        do_write(8'd3, 32'h0000_0055, 4'b0001);
        chk_read(8'd3, "scratch_merge");
        check("scratch_const", 64'(scr_m), 64'h0000_0000_DEAD_BE55);

        // Read and write together: read serviced, write dropped.
        address = 8'd3; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        read = 1'b1; write = 1'b1;
        @(negedge clock);
        read = 1'b0; write = 1'b0; byteenable = 4'h0;
        check("rw.valid", 64'(readdatavalid), 64'd1);
        check("rw.data", 64'(readdata), 64'(scr_m));
        chk_read(8'd3, "rw_dropped");

        do_write(8'd0, 32'h0, 4'hF);
        chk_read(8'd0, "ro_write");
        do_write(8'd6, 32'h2, 4'b0010);
        chk_read(8'd6, "ctrl_lane0_off");

        chk_read(8'd4, "lo_a");
        chk_read(8'd4, "lo_b");
        chk_read(8'd5, "hi_small");

        // Preload the counter just below the 32-bit rollover.
        force dut.u_uptime.count_q = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_uptime.count_q;
        up_base = 64'h0000_0000_FFFF_FFFE;
        up_edge = cyc;
        chk_read(8'd4, "lo_pre_wrap");
        repeat (3) @(negedge clock);
        chk_read(8'd5, "hi_coherent");
        chk_read(8'd4, "lo_post_wrap");
        chk_read(8'd5, "hi_post_wrap");

        do_write(8'd6, 32'h2, 4'b0001);
        chk_read(8'd6, "ctrl_freeze");
        chk_read(8'd4, "frz_a");
        repeat (10) @(negedge clock);
        chk_read(8'd4, "frz_b");
        do_write(8'd6, 32'h3, 4'b0001);
        chk_read(8'd4, "clr_frozen");
        do_write(8'd6, 32'h0, 4'b0001);
        chk_read(8'd4, "run_a");
        chk_read(8'd4, "run_b");
        chk_read(8'd5, "hi_after_clr");

        for (int k = 0; k < 4; k++) chk_read(8'(8 + k), "user");
        chk_read(8'd12, "unmapped12");
        chk_read(8'd7, "reserved7");
        chk_read(8'd255, "unmapped255");

        repeat (80) begin
            case ($urandom_range(0, 3))
                0: do_write(8'd3, $urandom, 4'($urandom_range(0, 15)));
                1: chk_read(($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15)), "rnd_read");
                2: begin
                    uw[$urandom_range(0, 3)] = $urandom;
                    push_user();
                    @(negedge clock);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) do_write(8'd6, 32'($urandom_range(0, 3)), 4'b0001);
                    chk_read(8'd4, "rnd_lo");
                    chk_read(8'd5, "rnd_hi");
                end
            endcase
        end

        // Reset landing on a read cycle: no valid, everything back to reset values.
        do_write(8'd6, 32'h2, 4'b0001);
        do_write(8'd3, 32'hCAFE_F00D, 4'hF);
        address = 8'd4;
        read    = 1'b1;
        #2 reset = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check("mid_rst.valid", 64'(readdatavalid), 64'd0);
        check("mid_rst.data", 64'(readdata), 64'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("post_rst.valid", 64'(readdatavalid), 64'd0);
        held = readdata;
        check("post_rst.data", 64'(held), 64'd0);
        chk_read(8'd3, "post_rst_scratch");
        chk_read(8'd6, "post_rst_ctrl");
        chk_read(8'd4, "post_rst_lo");
        chk_read(8'd5, "post_rst_hi");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
